// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO
// or a pop from an empty one is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer
// that chains frames back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_byte,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(UART_DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(UART_DATA_BITS - 1);

  uart_state_t state_q, state_d;

  logic [BW-1:0] baud_q, baud_d;
  logic [NW-1:0] bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          baud_done;

  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready;
  assign baud_done = (baud_q == BAUD_LAST);
  assign tx        = tx_q;
  assign busy      = busy_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_byte),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_START;
      end
      ST_START: begin
        if (baud_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_done && bit_q == BIT_LAST) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_done) state_d = empty ? ST_IDLE : ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Popping the next byte at the end of a stop bit keeps frames gapless.
  always_comb begin
    pop     = 1'b0;
    tx_d    = tx_q;
    baud_d  = baud_done ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop  = 1'b1;
          tx_d = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) tx_d = shift_q[0];
      end
      ST_DATA: begin
        if (baud_done) begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = (bit_q == BIT_LAST) ? 1'b1 : shift_q[1];
        end
      end
      ST_STOP: begin
        if (baud_done && !empty) begin
          pop  = 1'b1;
          tx_d = 1'b0;
        end else if (baud_done) begin
          tx_d = 1'b1;
        end
      end
      default: tx_d = 1'b1;
    endcase
    if (pop) begin
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
    end
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a serial-line frame decoder.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] rx_q[$];
  int         st_q[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("send_timeout", 32'(t), 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  // Frame decoder: samples mid-bit, offsets counted from the start edge.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        st_q.push_back(cyc);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          b[j] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    logic [9:0] frame_a5;
    int         acc [6];
    int         k;
    int         prev_cnt;
    bit         rdy;
    int         t;
    int         bad;

    frame_a5 = 10'b1101001010;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ready", 32'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 1);

    // Single byte 0xA5
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    check("n_count", 32'(fifo_count), 1);
    check("n_tx", 32'(tx), 1);
    check("n_busy", 32'(busy), 0);
    @(negedge clk);
    check("n1_tx", 32'(tx), 0);
    check("n1_busy", 32'(busy), 1);
    check("n1_count", 32'(fifo_count), 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i), 32'(tx), 32'(frame_a5[i]));
      if (i < 9) repeat (CPB) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("n40_busy", 32'(busy), 1);
    @(negedge clk);
    check("n41_busy", 32'(busy), 0);
    check("n41_tx", 32'(tx), 1);
    wait_rx(1);
    if (rx_q.size() > 0) check("a5_rx", 32'(rx_q[0]), 32'h0A5);

    // Burst of six with back-pressure and a full+pop collision
    rx_q.delete();
    st_q.delete();
    k        = 0;
    t        = 0;
    prev_cnt = 0;
    in_valid = 1'b1;
    while (k < 6 && t < 1000) begin
      in_byte = 8'(k);
      rdy     = in_ready;
      if (k == 5 && rdy) begin
        check("col_prev", 32'(prev_cnt), 4);
        check("col_count", 32'(fifo_count), 3);
      end
      prev_cnt = 32'(fifo_count);
      @(negedge clk);
      t++;
      if (rdy) begin
        acc[k] = cyc;
        k++;
        if (k == 5) begin
          check("full_ready", 32'(in_ready), 0);
          check("full_count", 32'(fifo_count), 4);
        end
      end
    end
    in_valid = 1'b0;
    check("burst_accepted", 32'(k), 6);
    for (int i = 1; i < 5; i++)
      check($sformatf("acc%0d", i), 32'(acc[i] - acc[0]), 32'(i));
    check("acc5", 32'(acc[5] - acc[0]), 42);
    wait_rx(6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check($sformatf("burst_rx%0d", i), 32'(rx_q[i]), 32'(i));
    for (int i = 1; i < 6 && i < st_q.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(st_q[i] - st_q[i-1]),
            32'(10 * CPB));

    // Back-to-back 0xFF then 0x00
    repeat (50) @(negedge clk);
    rx_q.delete();
    st_q.delete();
    send(8'hFF);
    send(8'h00);
    wait_rx(2);
    if (rx_q.size() >= 2) begin
      check("b2b_rx0", 32'(rx_q[0]), 32'h0FF);
      check("b2b_rx1", 32'(rx_q[1]), 32'h000);
      check("b2b_gap", 32'(st_q[1] - st_q[0]), 32'(10 * CPB));
    end

    // Reset during the data bits of 0x3C
    repeat (50) @(negedge clk);
    send(8'h3C);
    repeat (14) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_tx", 32'(tx), 1);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_count", 32'(fifo_count), 0);
    check("mrst_ready", 32'(in_ready), 0);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_idle", 32'(bad), 0);
    rx_q.delete();
    st_q.delete();
    send(8'h3C);
    wait_rx(1);
    if (rx_q.size() > 0) check("post_rst_rx", 32'(rx_q[0]), 32'h03C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-stream UART transmitter that sits directly downstream of the convolutional encoder's packed byte output. It accepts bytes on a valid/ready handshake into a small synchronous FIFO and serialises each byte as an 8N1 frame (start, 8 data bits LSB-first, stop) on a single `tx` line. It decouples the encoder's bursty output from the fixed line rate, so the encoder sees back-pressure only when the FIFO is full.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: byte entries; must be a power of 2, ≥ 2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream byte present.
- `in_ready`  out  1  FIFO can accept a byte this cycle.
- `in_byte`  in  8  byte to transmit.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  serializer mid-frame (state ≠ IDLE).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

## Operation
- Push: on a rising edge with `in_valid && in_ready`, `in_byte` is written at the write pointer and the pointer increments, wrapping modulo FIFO_DEPTH.
- `in_ready` = (`fifo_count` != FIFO_DEPTH) && !`rst`. It does not look ahead to a same-cycle pop. When full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop: `fifo_count` is unchanged, and both pointers advance.
- Serializer FSM states: IDLE, START, DATA, STOP.
- IDLE → START: when `fifo_count` > 0, pop the head byte into an 8-bit shift register, clear the bit counter and the baud counter, and set `tx` to 0.
- START → DATA: after CLKS_PER_BIT cycles, drive `tx` from shift-register bit 0.
- DATA: every CLKS_PER_BIT cycles, shift right and drive the next bit. After the 8th data bit completes, go to STOP and set `tx` to 1.
- STOP → START: at the end of the stop bit, if `fifo_count` > 0, pop immediately and set `tx` to 0. There is no idle gap between frames.
- STOP → IDLE: at the end of the stop bit, if the FIFO is empty.
- The baud counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1, then wraps to 0.
- The data-bit counter is 3 bits and counts 0..7.
- Reset mid-frame:
  - Abort the frame and discard all FIFO contents.
  - `tx` returns to 1 on the reset edge.
  - There is no partial-frame completion.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=0 while `rst` is high and 1 on the first cycle after release. Pointers, counters and state are cleared, with state = IDLE.
- `tx` and `busy` are registered outputs. `in_ready` is combinational from `fifo_count` and `rst`.
- Latency: a byte accepted at edge N into an empty FIFO with the serializer IDLE is popped at edge N+1. `tx` falls at edge N+1 and `busy` rises at edge N+1.
- Each bit holds for exactly CLKS_PER_BIT cycles. A frame is 10×CLKS_PER_BIT cycles.
- Back-to-back frames start exactly 10×CLKS_PER_BIT cycles apart.
- `fifo_count` reflects a push or pop on the edge after which it occurs.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP).
  - `UART_DATA_BITS`=8 and `UART_FRAME_BITS`=10.
- Sub-module `sync_fifo`, parameterised by width and depth, providing push, pop, full, empty and count. It is reusable by the upstream UART receive path.
- The top level holds the serializer FSM, baud counter and shift register.

## Test plan
- **Single byte** (CLKS_PER_BIT=4): send 0xA5 at edge N.
  - `tx` falls at N+1.
  - `tx` sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `busy` drops 40 cycles after N+1.
- **Burst with back-pressure**: send 6 bytes 0x00..0x05 (FIFO_DEPTH=4) with `in_valid` held high.
  - Bytes 0–4 are accepted on consecutive edges, then `in_ready`=0.
  - Byte 5 is accepted on the edge after frame 0 ends.
  - All 6 frames are decoded in order.
- **Back-to-back frames**: send 0xFF then 0x00.
  - The second start bit falls exactly 10×CLKS_PER_BIT cycles after the first.
  - `tx` is never high for more than one bit between frames.
- **Full + pop collision**: with the FIFO full and a pop occurring on the same edge as an attempted push, the push is refused and `fifo_count` goes 4→3.
- **Reset mid-frame**: assert `rst` for 1 cycle during the DATA bit of 0x3C.
  - `tx`=1, `busy`=0 and `fifo_count`=0 on the next edge.
  - No further frame starts until a new byte is pushed.
- **Encoder integration**: chain the encoder output into this block and send input byte 0x3C. The 2 resulting output bytes are recovered from `tx` by a bench UART decoder and match the golden encoder model.
